// File: rtl/keypad_event_debounce.sv
// Synchronises and debounces 8 raw keys and emits one held one-hot event per clean press.
// Optional auto-repeat while a key is held: define KEYPAD_EVENT_REPEAT_EN.
`timescale 1ns/1ps
module keypad_event_debounce #(
  parameter int unsigned TICK_DIV      = 1000,
  parameter int unsigned DB_TICKS      = 4,
  parameter int unsigned PULSE_CYCLES  = 16,
  parameter int unsigned REPEAT_DELAY  = 250,
  parameter int unsigned REPEAT_PERIOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw_keys,
  output logic [7:0] keypad,
  output logic [7:0] key_level,
  output logic       event_busy,
  output logic       overrun
);

  localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [TW-1:0] TickLast  = TW'(TICK_DIV - 1);
  localparam logic [3:0]    DbLast    = 4'(DB_TICKS - 1);
  localparam logic [PW-1:0] PulseLoad = PW'(PULSE_CYCLES - 1);

  if (TICK_DIV < 2 || DB_TICKS < 1 || DB_TICKS > 15 || PULSE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("keypad_event_debounce: illegal parameter value");
  end

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StPulse   = 2'b01,
    StWaitRel = 2'b10
  } state_e;

  logic [7:0]      sync_meta;
  logic [7:0]      sync;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [7:0][3:0] db_cnt;
  logic [7:0]      key_level_q;
  logic [7:0]      rise;
  logic [7:0]      rise_lsb;
  logic [7:0]      rise_extra;
  state_e          state;
  logic [7:0]      sel;
  logic [PW-1:0]   pcnt;

  // Two-flop synchroniser per key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= raw_keys;
      sync      <= sync_meta;
    end
  end

  assign tick = (tick_cnt == TickLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A key's level only flips after DB_TICKS consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt    <= '0;
      key_level <= '0;
    end else if (tick) begin
      for (int i = 0; i < 8; i++) begin
        if (sync[i] == key_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DbLast) begin
          key_level[i] <= sync[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_level_q <= '0;
    end else begin
      key_level_q <= key_level;
    end
  end

  assign rise       = key_level & ~key_level_q;
  assign rise_lsb   = rise & (~rise + 8'd1);
  assign rise_extra = rise & ~rise_lsb;
  assign event_busy = (state != StIdle);

`ifdef KEYPAD_EVENT_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW     = $clog2(RepMax + 1);
  localparam logic [RW-1:0] RepDelayLoad  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RepPeriodLoad = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  logic          rpt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= StIdle;
      sel     <= '0;
      keypad  <= '0;
      pcnt    <= '0;
      overrun <= 1'b0;
      rcnt    <= '0;
      rpt     <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (|rise) begin
            sel    <= rise_lsb;
            keypad <= rise_lsb;
            pcnt   <= PulseLoad;
            rpt    <= 1'b0;
            state  <= StPulse;
            if (|rise_extra) overrun <= 1'b1;
          end
        end
        StPulse: begin
          if (|rise) overrun <= 1'b1;
          if (pcnt == '0) begin
            keypad <= '0;
            rcnt   <= rpt ? RepPeriodLoad : RepDelayLoad;
            state  <= StWaitRel;
          end else begin
            pcnt <= pcnt - 1'b1;
          end
        end
        StWaitRel: begin
          if (|rise) overrun <= 1'b1;
          // Release wins over a coincident repeat.
          if ((key_level & sel) == '0) begin
            sel   <= '0;
            state <= StIdle;
          end else if (tick) begin
            if (rcnt == '0) begin
              keypad <= sel;
              pcnt   <= PulseLoad;
              rpt    <= 1'b1;
              state  <= StPulse;
            end else begin
              rcnt <= rcnt - 1'b1;
            end
          end
        end
        default: begin
          state  <= StIdle;
          keypad <= '0;
          sel    <= '0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= StIdle;
      sel     <= '0;
      keypad  <= '0;
      pcnt    <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (|rise) begin
            sel    <= rise_lsb;
            keypad <= rise_lsb;
            pcnt   <= PulseLoad;
            state  <= StPulse;
            if (|rise_extra) overrun <= 1'b1;
          end
        end
        StPulse: begin
          if (|rise) overrun <= 1'b1;
          if (pcnt == '0) begin
            keypad <= '0;
            state  <= StWaitRel;
          end else begin
            pcnt <= pcnt - 1'b1;
          end
        end
        StWaitRel: begin
          if (|rise) overrun <= 1'b1;
          if ((key_level & sel) == '0) begin
            sel   <= '0;
            state <= StIdle;
          end
        end
        default: begin
          state  <= StIdle;
          keypad <= '0;
          sel    <= '0;
        end
      endcase
    end
  end
`endif

endmodule

// File: doc/keypad_event_debounce.md
Name: keypad_event_debounce

Overview:
- Upstream stage of the keypad-driven VGA movement FSM; sits between the raw push-button pins and that FSM's `keypad[7:0]` input.
- Synchronises and debounces 8 raw keys, then turns each clean press into a one-hot event.
- Holds each event for a fixed number of cycles, long enough for the FSM to see it in its key-poll state.
- Emits exactly one event per physical press: no repeats while the key is held, and no bounce glitches.

Parameters:
- TICK_DIV, 1000: clk cycles per debounce sample tick (≥2).
- DB_TICKS, 4: consecutive disagreeing ticks needed to flip a key's debounced level (1..15).
- PULSE_CYCLES, 16: cycles each one-hot event is held on `keypad` (≥1; must exceed the consumer's worst-case poll loop).
- REPEAT_DELAY, 250: ticks from press to first auto-repeat (used only with the optional feature).
- REPEAT_PERIOD, 60: ticks between auto-repeats (used only with the optional feature).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous reset, active-low; asserted when 0.
- `raw_keys`  in  8  unsynchronised button levels, 1 = pressed.
- `keypad`  out  8  one-hot press event (bit0 left, bit1 right, bit2 down, bit3 up, bits 4-7 spare); 0 when idle.
- `key_level`  out  8  debounced level of every key.
- `event_busy`  out  1  high while the FSM is in PULSE or WAIT_REL.
- `overrun`  out  1  sticky; set when a press edge is dropped.

Behaviour:
- Reset: while `rst`=0, clear every register immediately and asynchronously:
  - outputs: `keypad`=0, `key_level`=0, `event_busy`=0, `overrun`=0;
  - internal: synchronisers=0, tick counter=0, debounce counters=0, FSM=IDLE.
- Synchroniser: two flops per bit; `raw_keys` reaches `sync` after 2 clk.
- Tick: counter runs 0..TICK_DIV-1 and wraps. `tick`=1 for one cycle when the count equals TICK_DIV-1.
- Debounce, per bit i, evaluated only on tick:
  - if `sync[i]` == `key_level[i]`: `cnt[i]`←0;
  - else if `cnt[i]` == DB_TICKS-1: `key_level[i]`←`sync[i]` and `cnt[i]`←0;
  - else: `cnt[i]`←`cnt[i]`+1.
  - A bounce (sync returns to level before DB_TICKS ticks) resets the count; `key_level` does not change.
- Rise: `rise[i]` = `key_level[i]` & ~`key_level_q[i]`, where `key_level_q` is `key_level` delayed one cycle. It is a one-cycle pulse.
- Event FSM, 2-bit state:
  - IDLE: if `rise`≠0:
    - `sel`←one-hot of the lowest set bit of `rise`; `keypad`←`sel`;
    - `pcnt`←PULSE_CYCLES-1; go to PULSE.
    - Other simultaneous rise bits are dropped and set `overrun`.
  - PULSE: `keypad` holds `sel`.
    - If `pcnt`=0: `keypad`←0, go to WAIT_REL.
    - Else `pcnt`←`pcnt`-1.
    - Result: `keypad` is nonzero for exactly PULSE_CYCLES consecutive cycles.
  - WAIT_REL: if (`key_level` & `sel`)=0, go to IDLE, `sel`←0.
  - Unused encoding: go to IDLE with `keypad`=0.
- Drops: any `rise` occurring in PULSE or WAIT_REL is dropped and sets `overrun`. Only reset clears `overrun`.
- Latency: a clean press edge on `raw_keys` leads to `keypad` nonzero in at most 2 + TICK_DIV·DB_TICKS + 2 clk.
- Other keys: while one key is held, changes on other keys still debounce and update `key_level`. Their presses are dropped (flagging `overrun`); no event is queued.
- `event_busy` = (state≠IDLE).
- Release bounce: the key must debounce to 0 before the FSM returns to IDLE, so a release bounce never produces a second event.

Optional Feature:
- Macro: `KEYPAD_EVENT_REPEAT_EN`.
- Defined: WAIT_REL gains a tick counter `rcnt`.
  - On entering WAIT_REL from the first pulse: `rcnt`←REPEAT_DELAY-1.
  - On entering WAIT_REL from a repeat pulse: `rcnt`←REPEAT_PERIOD-1.
  - On each tick: if `rcnt`=0 and `sel` is still held, re-emit `sel` (load `pcnt`, go to PULSE); otherwise decrement.
  - Release still returns the FSM to IDLE immediately.
- Undefined: no `rcnt` logic exists and exactly one event is produced per press.

Test Plan (TICK_DIV=4, DB_TICKS=3, PULSE_CYCLES=8, macro undefined unless stated):
- Steady press: `raw_keys`=8'h02 held 100 clk → `keypad`=8'h02 within 16 clk of the edge, held exactly 8 cycles, then 0; `key_level`=8'h02; no second event.
- Bounce: `raw_keys`=8'h01 toggled every 5 clk for 40 clk, then 0 → `key_level` stays 0, `keypad` stays 0, `overrun`=0.
- Simultaneous press: `raw_keys` 0→8'h0C in one cycle → `keypad`=8'h04 for 8 cycles, `overrun`=1, no 8'h08 event.
- Release and repress: press 8'h08, release, wait 30 clk, press again → two separate 8-cycle 8'h08 events; `event_busy` low between them.
- Mid-pulse reset: drive `rst`=0 during PULSE → `keypad`, `key_level`, `event_busy`, `overrun` become 0 immediately; after `rst`=1 with the key still held, a fresh event occurs within 16 clk.
- With `KEYPAD_EVENT_REPEAT_EN`, REPEAT_DELAY=10, REPEAT_PERIOD=5: hold 8'h01 for 200 clk → first event, then repeats spaced 10 ticks then 5 ticks (each including 8-cycle pulses); release → no further events.
